simplez_uart_tx: RTL

Memory-mapped serial transmitter that sits on the responder side of the Simplez CPU bus, next to main memory and the LED port. It decodes the CPU's address, write strobe and data bus, buffers written bytes in a small FIFO, and shifts them out as 8N1 asynchronous serial. It returns a status word on reads with the same one-cycle registered latency as main memory, and the top level muxes it onto the data bus.

---
 rtl/simplez_pkg.sv | 30 +++
 rtl/simplez_fifo.sv | 69 ++++++
 rtl/simplez_uart_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez I/O responders.
// Holds bus widths, the I/O address map, UART status bit positions and the
// transmitter FSM state encoding.
package simplez_pkg;

  localparam int unsigned DATAW = 12;
  localparam int unsigned ADDRW = 9;

  // I/O address map
  localparam logic [8:0] ADDR_LED  = 9'o100;
  localparam logic [8:0] ADDR_STAT = 9'o506;
  localparam logic [8:0] ADDR_DATA = 9'o507;

  // Status word bit positions
  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_OVR    = 2;
  localparam int unsigned STAT_BUSY   = 3;
  localparam int unsigned STAT_CNT_LO = 4;
  localparam int unsigned STAT_CNT_HI = 7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/simplez_fifo.sv
// Synchronous first-word-fall-through FIFO, falling-edge clocked.
// Ports:
//   clk_i, rstn_i      clock (falling edge) and synchronous active-low reset
//   push_i, din_i      write request and data; accepted when not full or when
//                      a pop happens in the same cycle
//   pop_i, dout_o      read request (ignored when empty) and head-of-queue data
//   count_o            number of stored entries (one bit wider than pointers)
//   full_o, empty_o    occupancy flags
module simplez_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, do_push, do_pop;

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop_i & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is ok
    do_push = push_i & (~full | do_pop);
    // Pointers are exactly log2(DEPTH) wide and wrap on their own
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(negedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(negedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the Simplez CPU responder bus.
// Writes to ADDR_DATA queue a byte; ADDR_STAT reads return the status word
// {0, count[3:0], busy, ovr, full, empty} and writes with bit0 set clear ovr.
// Read data is registered one falling edge after the address, like main memory.
// Ports:
//   clk       system clock, all state changes on the falling edge
//   rstn      synchronous active-low reset
//   addr, wr, data_in   CPU address, write strobe and data bus
//   data_out  registered read data (0 when not selected)
//   sel       registered address hit, used by the top level to mux data_out
//   tx        serial line, idle high
//   busy      FIFO non-empty or a frame in flight
// Build option: define SIMPLEZ_TX_PARITY_EN to append an even-parity bit
// between the data bits and the stop bit.
module simplez_uart_tx #(
  parameter int unsigned      DATAW      = simplez_pkg::DATAW,
  parameter int unsigned      ADDRW      = simplez_pkg::ADDRW,
  parameter int unsigned      BAUD_DIV   = 104,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [ADDRW-1:0] ADDR_DATA  = ADDRW'(simplez_pkg::ADDR_DATA),
  parameter logic [ADDRW-1:0] ADDR_STAT  = ADDRW'(simplez_pkg::ADDR_STAT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             sel,
  output logic             tx,
  output logic             busy
);

  import simplez_pkg::*;

  localparam int unsigned      CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned      BaudW    = 12;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);

  logic             hit_data, hit_stat, push, pop, ovf;
  logic [7:0]       fifo_dout;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty;
  logic [7:0]       cnt_wide;
  logic [DATAW-1:0] stat_word;

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ovr_q, ovr_d;
  logic [DATAW-1:0] dout_q, dout_d;
  logic             sel_q, sel_d;

  // Only the low byte of a data write is transmitted
  logic unused_data_hi;
  assign unused_data_hi = ^data_in[DATAW-1:8];

  simplez_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .push_i  (push),
    .din_i   (data_in[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Address decode, overrun flag and read register
  always_comb begin
    hit_data = (addr == ADDR_DATA);
    hit_stat = (addr == ADDR_STAT);
    push     = wr & hit_data;
    pop      = (state_q == StIdle) & ~fifo_empty;
    ovf      = push & fifo_full & ~pop;

    busy = ~fifo_empty | (state_q != StIdle);

    // Count of 16 in a 16-deep FIFO wraps to 0 here; full disambiguates
    cnt_wide  = 8'(fifo_count);
    stat_word = '0;
    stat_word[STAT_EMPTY] = fifo_empty;
    stat_word[STAT_FULL]  = fifo_full;
    stat_word[STAT_OVR]   = ovr_q;
    stat_word[STAT_BUSY]  = busy;
    stat_word[STAT_CNT_HI:STAT_CNT_LO] = cnt_wide[3:0];

    ovr_d = ovr_q;
    if (wr & hit_stat & data_in[0]) begin
      ovr_d = 1'b0;
    end
    // Overflow in the same cycle as a clear leaves the flag set
    if (ovf) begin
      ovr_d = 1'b1;
    end

    dout_d = hit_stat ? stat_word : '0;
    sel_d  = hit_data | hit_stat;
  end

  // Shifter FSM; every state exit happens on a baud tick, which also reloads
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    baud_d  = (baud_q == '0) ? BaudLast : baud_q - 1'b1;
    tx      = 1'b1;
    case (state_q)
      StIdle: begin
        baud_d = BaudLast;
        if (!fifo_empty) begin
          shreg_d = fifo_dout;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (baud_q == '0) begin
          state_d = StData;
        end
      end
      StData: begin
        tx = shreg_q[bit_q];
        if (baud_q == '0) begin
          if (bit_q == 3'd7) begin
`ifdef SIMPLEZ_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef SIMPLEZ_TX_PARITY_EN
      StParity: begin
        tx = ^shreg_q;
        if (baud_q == '0) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        tx = 1'b1;
        if (baud_q == '0) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      baud_q  <= BaudLast;
      bit_q   <= '0;
      shreg_q <= '0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
    end
  end

  assign data_out = dout_q;
  assign sel      = sel_q;

endmodule
